// File: rtl/load_store_unit_pkg.sv
// Shared LSU definitions: funct3 codes, FSM state encoding, request decode helpers.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP,
    S_ERR
  } lsu_state_t;

  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Alignment, legal-opcode and range check for an incoming request.
  function automatic logic req_error(input logic        we,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr,
                                     input logic [31:0] limit);
    logic err;
    case (f3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr[0];
      F3_W:    err = |addr[1:0];
      F3_BU:   err = we;
      F3_HU:   err = we | addr[0];
      default: err = 1'b1;
    endcase
    if (addr > limit - {29'd0, access_size(f3)}) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane logic for a word-only memory: load extract/extend and SB/SH merge.
// Latency: combinational.
// Backpressure: none.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [15:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign sh     = {lane, 3'b000};
  assign byte_v = 8'(old_word >> sh);
  assign half_v = lane[1] ? old_word[31:16] : old_word[15:0];

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
      F3_H:    load_data = {{16{half_v[15]}}, half_v};
      F3_W:    load_data = old_word;
      F3_BU:   load_data = {24'd0, byte_v};
      F3_HU:   load_data = {16'd0, half_v};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    merged = old_word;
    case (funct3)
      F3_B:    merged = (old_word & ~(32'h0000_00FF << sh)) | ({24'd0, wdata[7:0]} << sh);
      F3_H:    merged = lane[1] ? {wdata, old_word[15:0]} : {old_word[31:16], wdata};
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only data memory; SB/SH done as read-modify-write.
// Latency accept->rsp_valid: load 2, SW 2, SB/SH 3, error 1.
// Backpressure: req_ready only in IDLE; one request in flight.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 84
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

  lsu_state_t  state, state_nxt;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] wr_word;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        accept;
  logic        req_err;

  // Reset gates ready so nothing is accepted while the block is held in reset.
  assign req_ready = RST_n && (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_err   = req_error(req_we, req_funct3, req_addr, LIMIT);
  assign rsp_valid = (state == S_RESP) || (state == S_ERR);
  assign rsp_err   = (state == S_ERR);

  lsu_lane_align u_lane (
    .old_word  (mem_dout),
    .wdata     (r_wdata[15:0]),
    .funct3    (r_f3),
    .lane      (r_addr[1:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= S_IDLE;
      r_f3      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      wr_word   <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (accept) begin
          r_f3    <= req_funct3;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          if (req_err) rsp_rdata <= '0;
        end
        S_RD:     rsp_rdata <= load_data;
        S_RMW_RD: wr_word   <= merged;
        S_WR:     rsp_rdata <= '0;
        default: ;
      endcase
    end
  end

  // Memory strobes come from the state register only, never from req_* inputs.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_rw    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                  state_nxt = S_ERR;
          else if (!req_we)             state_nxt = S_RD;
          else if (req_funct3 == F3_W)  state_nxt = S_WR;
          else                          state_nxt = S_RMW_RD;
        end
      end
      S_RD: begin
        mem_en    = 1'b1;
        mem_addr  = {r_addr[31:2], 2'b00};
        state_nxt = S_RESP;
      end
      S_RMW_RD: begin
        mem_en    = 1'b1;
        mem_addr  = {r_addr[31:2], 2'b00};
        state_nxt = S_WR;
      end
      S_WR: begin
        mem_en    = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_din   = (r_f3 == F3_W) ? r_wdata : wr_word;
        state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 21-word word-only memory behind it.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  load_store_unit #(.ADDR_LIMIT(84)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 CLK = ~CLK;

  logic [31:0] mem [21] = '{default: 32'd0};
  assign mem_dout = (mem_addr[31:2] < 30'd21) ? mem[mem_addr[6:2]] : 32'd0;
  always @(posedge CLK)
    if (mem_en && mem_rw && mem_addr[31:2] < 30'd21) mem[mem_addr[6:2]] <= mem_din;

  typedef struct { logic [31:0] rdata; logic err; int lat; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] din; } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   acc_q[$];
  exp_t mon_e;
  wr_t  mon_w;
  int   mon_a;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   en_snap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: records accepts, checks every write cycle and every response.
  always @(negedge CLK) begin
    if (!RST_n) acc_q.delete();
    else begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (mem_en) begin
        en_cnt++;
        chk("ready_low_mem", {31'd0, req_ready}, 32'd0);
      end
      if (mem_en && mem_rw) begin
        if (wr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: addr 0x%08h din 0x%08h, none required", mem_addr, mem_din);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", mem_addr, mon_w.addr);
          chk("wr_din", mem_din, mon_w.din);
        end
      end
      if (rsp_valid) begin
        chk("ready_low_rsp", {31'd0, req_ready}, 32'd0);
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: rdata 0x%08h err %0d, none required", rsp_rdata, rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
          chk("latency", cyc - mon_a, mon_e.lat);
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input bit hold);
    int n;
    exp_q.push_back('{rdata: exp_rd, err: exp_err, lat: lat});
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: req_ready 0 after %0d cycles, required 1", n);
    end
    @(posedge CLK); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RST_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Word store/load and byte/half read-modify-write.
    wr_q.push_back('{32'h10, 32'hDEADBEEF});
    issue(1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0);
    issue(0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0);
    wr_q.push_back('{32'h0, 32'h12345678});
    issue(1, F3_W,  32'h0,  32'h12345678, 32'h0, 0, 2, 0);
    wr_q.push_back('{32'h8, 32'h11223344});
    issue(1, F3_W,  32'h8,  32'h11223344, 32'h0, 0, 2, 0);
    wr_q.push_back('{32'h8, 32'h11AA3344});
    issue(1, F3_B,  32'hA,  32'h123456AA, 32'h0, 0, 3, 0);
    issue(0, F3_W,  32'h8,  32'h0, 32'h11AA3344, 0, 2, 0);
    issue(0, F3_B,  32'hA,  32'h0, 32'hFFFFFFAA, 0, 2, 0);
    issue(0, F3_BU, 32'hA,  32'h0, 32'h000000AA, 0, 2, 0);
    issue(0, F3_B,  32'h8,  32'h0, 32'h00000044, 0, 2, 0);
    wr_q.push_back('{32'h4, 32'h80010000});
    issue(1, F3_H,  32'h6,  32'hCAFE8001, 32'h0, 0, 3, 0);
    issue(0, F3_H,  32'h6,  32'h0, 32'hFFFF8001, 0, 2, 0);
    issue(0, F3_HU, 32'h6,  32'h0, 32'h00008001, 0, 2, 0);
    issue(0, F3_H,  32'h4,  32'h0, 32'h00000000, 0, 2, 0);
    // Last word of the range is legal.
    wr_q.push_back('{32'h50, 32'hA5A5A5A5});
    issue(1, F3_W,  32'h50, 32'hA5A5A5A5, 32'h0, 0, 2, 0);
    issue(0, F3_B,  32'h53, 32'h0, 32'hFFFFFFA5, 0, 2, 0);
    issue(0, F3_HU, 32'h52, 32'h0, 32'h0000A5A5, 0, 2, 0);
    drain();

    // Error responses must never touch memory.
    en_snap = en_cnt;
    issue(0, F3_W,  32'h2,  32'h0, 32'h0, 1, 1, 0);
    issue(1, F3_H,  32'h3,  32'h1234, 32'h0, 1, 1, 0);
    issue(0, F3_B,  32'h54, 32'h0, 32'h0, 1, 1, 0);
    issue(0, 3'd3,  32'h0,  32'h0, 32'h0, 1, 1, 0);
    issue(1, F3_BU, 32'h0,  32'h0, 32'h0, 1, 1, 0);
    issue(0, F3_W,  32'h54, 32'h0, 32'h0, 1, 1, 0);
    issue(0, 3'd6,  32'h0,  32'h0, 32'h0, 1, 1, 0);
    drain();
    @(posedge CLK); #1;
    chk("err_no_mem_en", en_cnt, en_snap);

    // Back-to-back with req_valid held high.
    issue(0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 1);
    issue(0, F3_BU, 32'hB,  32'h0, 32'h00000011, 0, 2, 1);
    wr_q.push_back('{32'h14, 32'h00000001});
    issue(1, F3_W,  32'h14, 32'h00000001, 32'h0, 0, 2, 1);
    issue(0, F3_W,  32'h14, 32'h0, 32'h00000001, 0, 2, 0);
    drain();

    // Reset during the write cycle of a store.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h0;
    req_wdata  = 32'h00000055;
    @(posedge CLK); #1;
    chk("cut_wr_en", {31'd0, mem_en}, 32'd1);
    chk("cut_wr_rw", {31'd0, mem_rw}, 32'd1);
    chk("cut_wr_din", mem_din, 32'h00000055);
    RST_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("cut_mem_en", {31'd0, mem_en}, 32'd0);
    chk("cut_req_ready", {31'd0, req_ready}, 32'd0);
    chk("cut_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RST_n = 1'b1;
    #1;
    chk("cut_ready_after", {31'd0, req_ready}, 32'd1);
    issue(0, F3_W, 32'h0,  32'h0, 32'h12345678, 0, 2, 0);
    issue(0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0);
    drain();
    @(posedge CLK); @(posedge CLK); #1;

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("acc_q_empty", acc_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
